// File: rtl/fp_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_unit_arbiter
// Brief    : Round-robin issue arbiter in front of one shared, fully
//            pipelined, fixed-latency FP unit. Each issued operation carries
//            its valid bit and requester ID down a delay line matched to the
//            unit latency, so every result returns tagged to its originator.
// Revision : 1.0 - initial release
// ============================================================================
module fp_unit_arbiter #(
    parameter int NREQ    = 4,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 4
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [NREQ-1:0]                req_valid,
    input  logic [NREQ*DATA_W-1:0]         req_a,
    input  logic [NREQ*DATA_W-1:0]         req_b,
    output logic [NREQ-1:0]                req_ready,
    output logic                           unit_in_valid,
    output logic [DATA_W-1:0]              unit_a,
    output logic [DATA_W-1:0]              unit_b,
    input  logic [DATA_W-1:0]              unit_result,
    output logic                           res_valid,
    output logic [$clog2(NREQ)-1:0]        res_id,
    output logic [DATA_W-1:0]              res_data,
    output logic [$clog2(LATENCY+1)-1:0]   in_flight
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = $clog2(LATENCY+1);
    localparam int TOP   = LATENCY - 1;

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] win_id;
    logic [ID_W-1:0] scan_idx;
    logic            win_found;
    logic            issue;

    // Delay line of {valid, id}, stage 0 is loaded on every edge.
    logic [LATENCY-1:0] dl_valid;
    logic [ID_W-1:0]    dl_id [LATENCY];
    logic               retire;

    // Round-robin scan: first asserted request at or after ptr, wrapping.
    always_comb begin
        win_id    = '0;
        win_found = 1'b0;
        scan_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = ID_W'((int'(ptr) + i) % NREQ);
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
    end

    // Grant and operand steering; nothing is presented while in reset.
    always_comb begin
        issue     = resetn & win_found;
        req_ready = issue ? (NREQ'(1) << win_id) : '0;
        unit_a    = '0;
        unit_b    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (issue && (win_id == ID_W'(i))) begin
                unit_a = req_a[i*DATA_W +: DATA_W];
                unit_b = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    assign unit_in_valid = issue;
    assign retire        = dl_valid[TOP];

    // Pointer advances past the winner only when something issues.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr <= '0;
        end else if (issue) begin
            ptr <= (win_id == ID_W'(NREQ-1)) ? '0 : win_id + ID_W'(1);
        end
    end

    // Tag delay line; flushing it on reset discards ops still in the unit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dl_valid <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                dl_id[k] <= '0;
            end
        end else begin
            dl_valid[0] <= issue;
            dl_id[0]    <= win_id;
            for (int k = 1; k < LATENCY; k++) begin
                dl_valid[k] <= dl_valid[k-1];
                dl_id[k]    <= dl_id[k-1];
            end
        end
    end

    // Registered tagged result; id/data hold between pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_data  <= '0;
        end else begin
            res_valid <= retire;
            if (retire) begin
                res_id   <= dl_id[TOP];
                res_data <= unit_result;
            end
        end
    end

    // Occupancy: +1 per issue, -1 per retire, bounded by LATENCY.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_flight <= '0;
        end else begin
            case ({issue, retire})
                2'b10:   in_flight <= in_flight + CNT_W'(1);
                2'b01:   in_flight <= in_flight - CNT_W'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/fp_unit_arbiter.md
Name: fp_unit_arbiter

Overview:
Shares one fully pipelined, fixed-latency FP unit (e.g. an FP adder or multiplier) between NREQ requesters. Issues at most one operation per cycle, selected round-robin. Carries each issued operation's valid bit and requester ID down an internal delay line matched to the unit latency, so every result returns tagged to its originator. Sits between the rasteriser/shader issue logic and the shared FP datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA_W, 32, operand/result width (IEEE-754 single)
LATENCY, 4, unit latency in cycles from unit_in_valid to unit_result valid (>=1)

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester operation request
req_a  in  NREQ*DATA_W  operand A, requester i at bits [i*DATA_W +: DATA_W]
req_b  in  NREQ*DATA_W  operand B, same packing
req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
unit_in_valid  out  1  operation presented to FP unit this cycle
unit_a  out  DATA_W  operand A to unit
unit_b  out  DATA_W  operand B to unit
unit_result  in  DATA_W  unit output, valid exactly LATENCY cycles after issue
res_valid  out  1  tagged result valid (single-cycle pulse per result)
res_id  out  $clog2(NREQ)  requester ID of result
res_data  out  DATA_W  result value
in_flight  out  $clog2(LATENCY+1)  operations issued and not yet returned

Behaviour:
- Reset (resetn=0, asynchronous): delay line cleared; round-robin pointer=0; res_valid=0, res_id=0, res_data=0, in_flight=0. Ops in flight at reset are discarded, never reported.
- Arbitration is combinational from req_valid and the pointer. The winner is the first asserted req_valid scanning from index ptr upward, wrapping at NREQ.
- req_ready is one-hot on the winner and all-zero when no request or while resetn=0. It never depends on a result condition, so there is no backpressure: the unit accepts one op per cycle.
- unit_in_valid = |req_valid (0 in reset). unit_a/unit_b = winner's operands combinationally; 0 when idle.
- Pointer update on issue: ptr <= winner+1 mod NREQ. No issue: ptr holds.
- Delay line: LATENCY stages of {valid, id}. Stage 0 is loaded with {unit_in_valid, winner id} each cycle.
- Results are registered. At cycle t+LATENCY after issue at t, the top stage is {1,id}. On the next edge: res_valid<=1, res_id<=id, res_data<=unit_result. Total request-to-res_valid latency = LATENCY+1 cycles.
- res_data/res_id hold their last value when res_valid=0.
- in_flight: +1 on issue, -1 when the top stage is valid. Simultaneous issue and retire leaves it unchanged. Maximum value is LATENCY; no overflow is possible.
- Back-to-back issue every cycle gives back-to-back res_valid with IDs in issue order. Order is always preserved.
- Requester deasserting req_valid while not granted: allowed, no effect. Once granted in a cycle, the op is committed.

Test Plan:
1. Reset then idle: req_valid=0 for 20 cycles -> req_ready=0, unit_in_valid=0, res_valid=0, in_flight=0 throughout.
2. Single op: req 2 asserted one cycle with a=3f800000, b=3f000000, unit model returns a+b after 4 cycles -> req_ready=4'b0100 that cycle; res_valid pulses exactly 5 cycles later with res_id=2, res_data=3fc00000.
3. All four requesting continuously for 8 cycles from reset -> grants 0,1,2,3,0,1,2,3; eight consecutive res_valid pulses with res_id in the same sequence; in_flight saturates at 4.
4. Fairness skip: req_valid=4'b1010 held, ptr=0 -> grants alternate 1,3,1,3; requesters 0 and 2 are never granted.
5. Reset mid-operation: issue 3 ops, assert resetn=0 asynchronously between clock edges, release next cycle -> outputs clear immediately; no res_valid for the discarded ops; ptr=0; the next request is granted normally.
6. Sparse issue with LATENCY=1 build: ops on cycles 0, 2, 3 -> res_valid on cycles 2, 4, 5; in_flight never exceeds 1.
